// File: rtl/fbindct_coef_serializer.sv
// Quantizes an 8-coefficient binDCT vector (rounding shift + saturation) and
// streams it out one coefficient per cycle with index/last markers.
module fbindct_coef_serializer #(
    parameter int unsigned IN_WIDTH  = 20,
    parameter int unsigned OUT_WIDTH = 12,
    parameter logic [31:0] QSHIFT    = {8{4'd2}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0][IN_WIDTH-1:0]      y_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [OUT_WIDTH-1:0]          coef_out,
    output logic [2:0]                    coef_idx,
    output logic                          coef_valid,
    output logic                          coef_last,
    input  logic                          coef_ready,
    output logic                          sat_flag
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic signed [IN_WIDTH:0] QMAX = (IN_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH:0] QMIN = ~QMAX;

    state_t                       state_q, state_d;
    logic [7:0][OUT_WIDTH-1:0]    q_buf;
    logic [7:0][OUT_WIDTH-1:0]    q_new;
    logic [7:0]                   sat_new;
    logic [2:0]                   idx_q;
    logic [2:0]                   idx_nxt;
    logic [OUT_WIDTH-1:0]         coef_q;
    logic                         sat_q;
    logic                         capture;
    logic                         advance;

    // Result is {sat, value}; the add is one bit wider than the input so the
    // rounding constant can never overflow before the arithmetic shift.
    function automatic logic [OUT_WIDTH:0] quantize(input logic [IN_WIDTH-1:0] y,
                                                    input logic [3:0] s);
        logic signed [IN_WIDTH:0] rnd;
        logic signed [IN_WIDTH:0] t;
        logic signed [IN_WIDTH:0] r;
        rnd = (s != 4'd0) ? ((IN_WIDTH+1)'(1) << (s - 4'd1)) : '0;
        t   = $signed({y[IN_WIDTH-1], y}) + rnd;
        r   = t >>> s;
        if (r > QMAX)
            quantize = {1'b1, QMAX[OUT_WIDTH-1:0]};
        else if (r < QMIN)
            quantize = {1'b1, QMIN[OUT_WIDTH-1:0]};
        else
            quantize = {1'b0, r[OUT_WIDTH-1:0]};
    endfunction

    always_comb begin
        q_new   = '0;
        sat_new = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            {sat_new[k], q_new[k]} = quantize(y_in[k], QSHIFT[4*k +: 4]);
        end
    end

    assign capture = (state_q == IDLE) && valid_in;
    assign advance = (state_q == DRAIN) && coef_ready;
    assign idx_nxt = idx_q + 3'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in) state_d = DRAIN;
            DRAIN:   if (coef_ready && (idx_q == 3'd7)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_buf  <= '0;
            idx_q  <= '0;
            coef_q <= '0;
            sat_q  <= 1'b0;
        end else if (capture) begin
            q_buf  <= q_new;
            idx_q  <= '0;
            coef_q <= q_new[0];
            sat_q  <= |sat_new;
        end else if (advance) begin
            idx_q  <= idx_nxt;
            coef_q <= q_buf[idx_nxt];
        end
    end

    assign ready_out  = (state_q == IDLE);
    assign coef_valid = (state_q == DRAIN);
    assign coef_idx   = idx_q;
    assign coef_last  = (state_q == DRAIN) && (idx_q == 3'd7);
    assign coef_out   = coef_q;
    assign sat_flag   = sat_q;

endmodule
